// File: rtl/fp_enco.sv
// fp_enco: packs a sign / biased exponent / extended mantissa triple into an
// IEEE-754 single. The block normalizes one bit per cycle, rounds to nearest
// even, and then saturates or flushes the result. Handshake is valid/ready.
module fp_enco (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        Signo_in,
    input  logic [9:0]  Exponente_in,
    input  logic [26:0] Mantissa_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Float_num_out,
    output logic        Overflow,
    output logic        Underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    // One extra bit of headroom so exp+1 on a carry never wraps.
    logic signed [10:0] exp_q, exp_d;
    logic [26:0]        mant_q, mant_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    // Rounding datapath, used only in ROUND.
    logic               rnd_s;
    logic               carry_s;
    logic [22:0]        frac_s;
    logic signed [10:0] exp_r_s;

    // Next-state, datapath and registered output decode.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        out_valid_d = out_valid_q;

        // Round half to even: guard set and (sticky set or LSB odd).
        rnd_s   = mant_q[1] & (mant_q[0] | mant_q[2]);
        // The hidden bit is always 1 in ROUND, so a carry-out happens
        // exactly when the whole fraction is ones; the fraction add wraps
        // to zero in that same case, giving mantissa 1.0.
        carry_s = rnd_s & (&mant_q[25:2]);
        frac_s  = mant_q[24:2] + {22'd0, rnd_s};
        if (carry_s) begin
            exp_r_s = exp_q + 11'sd1;
        end else begin
            exp_r_s = exp_q;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = Signo_in;
                    exp_d   = {Exponente_in[9], Exponente_in};
                    mant_d  = Mantissa_in;
                    state_d = NORM;
                end else begin
                    state_d = IDLE;
                end
            end
            NORM: begin
                if (mant_q == 27'd0) begin
                    result_d    = {sign_q, 31'd0};
                    ovf_d       = 1'b0;
                    unf_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (mant_q[26]) begin
                    // Shift right one place, folding the dropped bit into sticky.
                    mant_d  = {1'b0, mant_q[26:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + 11'sd1;
                    state_d = ROUND;
                end else if (mant_q[25]) begin
                    state_d = ROUND;
                end else if (exp_q > 11'sd1) begin
                    mant_d  = {mant_q[25:0], 1'b0};
                    exp_d   = exp_q - 11'sd1;
                    state_d = NORM;
                end else begin
                    // Would go subnormal: flush to signed zero.
                    result_d    = {sign_q, 31'd0};
                    ovf_d       = 1'b0;
                    unf_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            ROUND: begin
                if (exp_r_s >= 11'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d    = 1'b1;
                    unf_d    = 1'b0;
                end else if (exp_r_s <= 11'sd0) begin
                    result_d = {sign_q, 31'd0};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_r_s[7:0], frac_s};
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= 11'sd0;
            mant_q      <= 27'd0;
            result_q    <= 32'd0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign Float_num_out = result_q;
    assign Overflow      = ovf_q;
    assign Underflow     = unf_q;

endmodule

// File: tb/tb_fp_enco.sv
// Directed bench for fp_enco: hand-computed vectors, latency, backpressure
// and reset behaviour.
module tb_fp_enco;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        Signo_in;
    logic [9:0]  Exponente_in;
    logic [26:0] Mantissa_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Float_num_out;
    logic        Overflow;
    logic        Underflow;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [26:0] m;
        logic [31:0] f;
        logic        o;
        logic        u;
        int          lat;
    } vec_t;

    fp_enco dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .Signo_in      (Signo_in),
        .Exponente_in  (Exponente_in),
        .Mantissa_in   (Mantissa_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .Float_num_out (Float_num_out),
        .Overflow      (Overflow),
        .Underflow     (Underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one operand, waits for acceptance, then counts edges
    // (accept edge = 1) until out_valid; leaves the result pending.
    task automatic do_op(input logic s, input logic [9:0] e, input logic [26:0] m,
                         output int lat);
        @(negedge clk);
        Signo_in     = s;
        Exponente_in = e;
        Mantissa_in  = m;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if ({Float_num_out, Overflow, Underflow} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%b/%b expected 0/0/0",
                     Float_num_out, Overflow, Underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normalized;
        vec_t v[6];
        int   lat;
        v[0] = '{1'b0, 10'd127, 27'h2000000, 32'h3F800000, 1'b0, 1'b0, 3};
        v[1] = '{1'b0, 10'd127, 27'h3FFFFFE, 32'h40000000, 1'b0, 1'b0, 3};
        v[2] = '{1'b0, 10'd127, 27'h2000006, 32'h3F800002, 1'b0, 1'b0, 3};
        v[3] = '{1'b0, 10'd127, 27'h2000002, 32'h3F800000, 1'b0, 1'b0, 3};
        v[4] = '{1'b1, 10'd127, 27'h2000003, 32'hBF800001, 1'b0, 1'b0, 3};
        v[5] = '{1'b0, 10'd0,   27'h2000000, 32'h00000000, 1'b0, 1'b1, 3};
        for (int i = 0; i < 6; i++) begin
            do_op(v[i].s, v[i].e, v[i].m, lat);
            n_checks++;
            if ({Float_num_out, Overflow, Underflow} !== {v[i].f, v[i].o, v[i].u}) begin
                n_fail++;
                $display("FAIL normalized[%0d]: got %h O=%b U=%b expected %h O=%b U=%b",
                         i, Float_num_out, Overflow, Underflow, v[i].f, v[i].o, v[i].u);
            end
            n_checks++;
            if (lat != v[i].lat) begin
                n_fail++;
                $display("FAIL normalized_lat[%0d]: got %0d expected %0d", i, lat, v[i].lat);
            end
            consume();
        end
    endtask

    task automatic test_carry;
        vec_t v[3];
        int   lat;
        v[0] = '{1'b0, 10'd127, 27'h6000000, 32'h40400000, 1'b0, 1'b0, 3};
        v[1] = '{1'b0, 10'd127, 27'h6000006, 32'h40400001, 1'b0, 1'b0, 3};
        v[2] = '{1'b1, 10'd254, 27'h6000000, 32'hFF800000, 1'b1, 1'b0, 3};
        for (int i = 0; i < 3; i++) begin
            do_op(v[i].s, v[i].e, v[i].m, lat);
            n_checks++;
            if ({Float_num_out, Overflow, Underflow} !== {v[i].f, v[i].o, v[i].u}) begin
                n_fail++;
                $display("FAIL carry[%0d]: got %h O=%b U=%b expected %h O=%b U=%b",
                         i, Float_num_out, Overflow, Underflow, v[i].f, v[i].o, v[i].u);
            end
            n_checks++;
            if (lat != v[i].lat) begin
                n_fail++;
                $display("FAIL carry_lat[%0d]: got %0d expected %0d", i, lat, v[i].lat);
            end
            consume();
        end
    endtask

    task automatic test_normalize_left;
        vec_t v[3];
        int   lat;
        v[0] = '{1'b0, 10'd130, 27'h0800000, 32'h40000000, 1'b0, 1'b0, 5};
        v[1] = '{1'b0, 10'd2,   27'h1000000, 32'h00800000, 1'b0, 1'b0, 4};
        v[2] = '{1'b1, 10'd1,   27'h1000000, 32'h80000000, 1'b0, 1'b1, 2};
        for (int i = 0; i < 3; i++) begin
            do_op(v[i].s, v[i].e, v[i].m, lat);
            n_checks++;
            if ({Float_num_out, Overflow, Underflow} !== {v[i].f, v[i].o, v[i].u}) begin
                n_fail++;
                $display("FAIL normalize[%0d]: got %h O=%b U=%b expected %h O=%b U=%b",
                         i, Float_num_out, Overflow, Underflow, v[i].f, v[i].o, v[i].u);
            end
            n_checks++;
            if (lat != v[i].lat) begin
                n_fail++;
                $display("FAIL normalize_lat[%0d]: got %0d expected %0d", i, lat, v[i].lat);
            end
            consume();
        end
    endtask

    // Runs right after an overflow result, so the flags must also clear.
    task automatic test_zero;
        int lat;
        do_op(1'b1, 10'd50, 27'h0000000, lat);
        n_checks++;
        if ({Float_num_out, Overflow, Underflow} !== {32'h80000000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL zero: got %h O=%b U=%b expected 80000000 O=0 U=0",
                     Float_num_out, Overflow, Underflow);
        end
        n_checks++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL zero_lat: got %0d expected 2", lat);
        end
        consume();
    endtask

    task automatic test_backpressure;
        int lat;
        do_op(1'b0, 10'd127, 27'h6000000, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({out_valid, in_ready, Float_num_out, Overflow, Underflow} !==
                {1'b1, 1'b0, 32'h40400000, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: got v=%b r=%b %h expected v=1 r=0 40400000",
                         i, out_valid, in_ready, Float_num_out);
            end
        end
        consume();
        n_checks++;
        if ({out_valid, in_ready, Float_num_out} !== {1'b0, 1'b1, 32'h40400000}) begin
            n_fail++;
            $display("FAIL after_consume: got v=%b r=%b %h expected v=0 r=1 40400000",
                     out_valid, in_ready, Float_num_out);
        end
    endtask

    task automatic test_reset_midflight;
        int   lat;
        logic seen;
        @(negedge clk);
        Signo_in     = 1'b0;
        Exponente_in = 10'd130;
        Mantissa_in  = 27'h0800000;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL busy_in_norm: got r=%b v=%b expected r=0 v=0", in_ready, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, Float_num_out} !== {1'b0, 1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b r=%b %h expected v=0 r=1 00000000",
                     out_valid, in_ready, Float_num_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: got out_valid seen=%b expected 0", seen);
        end
        do_op(1'b0, 10'd127, 27'h2000000, lat);
        n_checks++;
        if (Float_num_out !== 32'h3F800000 || lat != 3) begin
            n_fail++;
            $display("FAIL post_reset_op: got %h lat %0d expected 3F800000 lat 3",
                     Float_num_out, lat);
        end
        consume();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        Signo_in     = 1'b0;
        Exponente_in = 10'd0;
        Mantissa_in  = 27'd0;
        test_reset();
        test_normalized();
        test_carry();
        test_zero();
        test_normalize_left();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_enco.md
FP_ENCO -- requirements
Module: fp_enco

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: an operand triple is present on the inputs.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts an operand, high only in IDLE.
REQ-006 SHALL have port Signo_in, input, 1 bit: sign of the result.
REQ-007 SHALL have port Exponente_in, input, 10 bits: signed two's-complement biased exponent (bias 127).
REQ-008 SHALL have port Mantissa_in, input, 27 bits, fields as follows:
- [26] carry
- [25] hidden bit
- [24:2] fraction
- [1] guard
- [0] sticky
REQ-009 SHALL have port out_valid, output, 1 bit: Float_num_out and the flags are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port Float_num_out, output, 32 bits: packed IEEE-754 single {sign, exp[7:0], frac[22:0]}.
REQ-012 SHALL have ports Overflow and Underflow, outputs, 1 bit each: result saturated to infinity / flushed to zero.

Function
REQ-013 SHALL implement FSM states IDLE, NORM, ROUND, DONE.
REQ-014 SHALL, in IDLE, capture sign, exponent and mantissa into internal registers on in_valid && in_ready and go to NORM.
REQ-015 SHALL, in NORM with mantissa == 0, produce signed zero {S, 31'b0}, flags 0, and go to DONE.
REQ-016 SHALL, in NORM with m[26] == 1, set m <= {1'b0, m[26:2], m[1]|m[0]}, exp <= exp+1, and go to ROUND.
REQ-017 SHALL, in NORM with m[26:25] == 2'b01, leave m and exp unchanged and go to ROUND.
REQ-018 SHALL, in NORM with m[26:25] == 2'b00 and exp > 1, set m <= {m[25:0], 1'b0}, exp <= exp-1, and stay in NORM.
REQ-019 SHALL, in NORM with m[26:25] == 2'b00, m != 0 and exp <= 1, produce {S, 31'b0} with Underflow = 1 and go to DONE.
REQ-020 SHALL, in ROUND, round to nearest even: increment m[25:2] when m[1] && (m[0] || m[2]).
REQ-021 SHALL, when that increment carries out of m[25:2], set the mantissa to 1.0 (fraction 0) and exp <= exp+1.
REQ-022 SHALL pack the final (post-round) exponent as follows, then go to DONE:
- exp >= 255: {S, 8'hFF, 23'b0} with Overflow = 1
- exp <= 0: {S, 31'b0} with Underflow = 1
- otherwise: {S, exp[7:0], fraction}
REQ-023 SHALL, in DONE, assert out_valid; on out_valid && out_ready go to IDLE in the same edge.
REQ-024 SHALL hold Float_num_out, Overflow and Underflow stable while out_valid && !out_ready, and keep in_ready = 0 outside IDLE.
REQ-025 SHALL have latency (accept edge to out_valid high) of 3 cycles for carry or normalized inputs, plus 1 cycle per left shift; a zero mantissa takes 2 cycles.
REQ-026 SHALL keep Float_num_out and the flags unchanged from the previous result until DONE is entered again.

Reset
REQ-027 SHALL, on rst_n low, immediately and asynchronously:
- enter IDLE
- clear out_valid, Float_num_out, Overflow and Underflow to 0
- set in_ready = 1 once the block is in IDLE
REQ-028 SHALL, on reset asserted in NORM, ROUND or DONE, discard the pending operand and emit no output after reset release.

Verification
REQ-029 SHALL cover: S=0, E=127, M=27'h2000000 -> Float_num_out = 32'h3F800000, flags 0, out_valid 3 cycles after accept.
REQ-030 SHALL cover the carry case: S=0, E=127, M=27'h6000000 -> 32'h40400000, 3 cycles.
REQ-031 SHALL cover the left-normalize case: S=0, E=130, M=27'h0800000 -> 32'h40000000, 5 cycles.
REQ-032 SHALL cover the round tie with carry-out: S=0, E=127, M=27'h3FFFFFE -> 32'h40000000.
REQ-033 SHALL cover overflow: S=1, E=254, M=27'h6000000 -> 32'hFF800000, Overflow = 1.
REQ-034 SHALL cover zero, backpressure and reset:
- S=1, M=0 -> 32'h80000000 after 2 cycles
- out_ready held 0 for 5 cycles -> output stable, in_ready = 0
- rst_n pulsed low during NORM -> IDLE, out_valid = 0
